// File: rtl/farm_sensor_conditioner.sv
// farm_sensor_conditioner
//   Front end for the highway/farm traffic light controller. It synchronises
//   and debounces the farm-road loop sensor, keeps a count of queued farm
//   cars, retires one car every PASS_CYC farm-green cycles, and drives the
//   controller's car request `c`. Because the controller has no timers, `c`
//   is held off until the highway has been green for MIN_HW cycles, and it
//   is forced low once the farm has been green for MAX_FARM cycles.
//
// Ports
//   clk           : sole clock, rising edge
//   rst_n         : synchronous reset, active HIGH despite the name
//   sensor_raw    : asynchronous loop-detector level, 1 = vehicle present
//   light_farm    : controller feedback, one-hot RED=100 YELLOW=010 GREEN=001
//   light_highway : same encoding as light_farm
//   c             : registered car request
//   car_count     : queued-car count
//   q_sat         : sticky, set when an arrival is dropped at full count
module farm_sensor_conditioner #(
    parameter int DEB_CYC  = 4,
    parameter int PASS_CYC = 8,
    parameter int MIN_HW   = 16,
    parameter int MAX_FARM = 64,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sensor_raw,
    input  logic [2:0]       light_farm,
    input  logic [2:0]       light_highway,
    output logic             c,
    output logic [CNT_W-1:0] car_count,
    output logic             q_sat
);

    localparam int DEB_W  = $clog2(DEB_CYC);
    localparam int PASS_W = $clog2(PASS_CYC + 1);
    localparam int HW_W   = $clog2(MIN_HW + 1);
    localparam int FARM_W = $clog2(MAX_FARM + 1);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYC - 1);
    localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(PASS_CYC - 1);
    localparam logic [HW_W-1:0]   HW_MAX    = HW_W'(MIN_HW);
    localparam logic [FARM_W-1:0] FARM_MAX  = FARM_W'(MAX_FARM);

    localparam logic [2:0] GREEN = 3'b001;

    function automatic logic is_onehot(input logic [2:0] v);
        return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
    endfunction

    logic              s1_q, s1_d, s2_q, s2_d;
    logic              deb_level_q, deb_level_d;
    logic              deb_prev_q, deb_prev_d;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic [CNT_W-1:0]  car_count_q, car_count_d;
    logic [PASS_W-1:0] pass_cnt_q, pass_cnt_d;
    logic [HW_W-1:0]   hw_cnt_q, hw_cnt_d;
    logic [FARM_W-1:0] farm_cnt_q, farm_cnt_d;
    logic              c_q, c_d;
    logic              q_sat_q, q_sat_d;

    logic lights_ok, farm_grn, hw_grn, arr, dep, gate;

    // Any malformed feedback (not one-hot, or both green) is treated as
    // "neither green": no departures, timers clear, request gate open.
    assign lights_ok = is_onehot(light_farm) && is_onehot(light_highway) &&
                       !((light_farm == GREEN) && (light_highway == GREEN));
    assign farm_grn  = lights_ok && (light_farm == GREEN);
    assign hw_grn    = lights_ok && (light_highway == GREEN);

    // Arrival fires in the cycle right after the debounced level rises,
    // so the count updates one edge after deb_level.
    assign arr = deb_level_q && !deb_prev_q;

    always_comb begin
        s1_d        = sensor_raw;
        s2_d        = s1_q;
        deb_level_d = deb_level_q;
        deb_prev_d  = deb_level_q;
        deb_cnt_d   = '0;
        pass_cnt_d  = '0;
        dep         = 1'b0;
        car_count_d = car_count_q;
        q_sat_d     = q_sat_q;
        hw_cnt_d    = '0;
        farm_cnt_d  = '0;
        gate        = 1'b1;

        // Debounce: a new level must persist DEB_CYC synchronised cycles.
        if (s2_q != deb_level_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                deb_level_d = s2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end

        // Departure timer only runs while there is someone to retire.
        if (farm_grn && (car_count_q != '0)) begin
            if (pass_cnt_q == PASS_LAST) begin
                dep = 1'b1;
            end else begin
                pass_cnt_d = pass_cnt_q + 1'b1;
            end
        end

        // Simultaneous arrival and departure cancel out.
        if (arr && !dep) begin
            if (&car_count_q) begin
                q_sat_d = 1'b1;
            end else begin
                car_count_d = car_count_q + 1'b1;
            end
        end else if (dep && !arr) begin
            car_count_d = car_count_q - 1'b1;
        end

        if (hw_grn) begin
            hw_cnt_d = (hw_cnt_q == HW_MAX) ? hw_cnt_q : hw_cnt_q + 1'b1;
        end
        if (farm_grn) begin
            farm_cnt_d = (farm_cnt_q == FARM_MAX) ? farm_cnt_q : farm_cnt_q + 1'b1;
        end

        if (hw_grn) begin
            gate = (hw_cnt_q >= HW_MAX);
        end else if (farm_grn) begin
            gate = (farm_cnt_q < FARM_MAX);
        end

        c_d = (car_count_d != '0) && gate;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            deb_level_q <= 1'b0;
            deb_prev_q  <= 1'b0;
            deb_cnt_q   <= '0;
            car_count_q <= '0;
            pass_cnt_q  <= '0;
            hw_cnt_q    <= '0;
            farm_cnt_q  <= '0;
            c_q         <= 1'b0;
            q_sat_q     <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            deb_level_q <= deb_level_d;
            deb_prev_q  <= deb_prev_d;
            deb_cnt_q   <= deb_cnt_d;
            car_count_q <= car_count_d;
            pass_cnt_q  <= pass_cnt_d;
            hw_cnt_q    <= hw_cnt_d;
            farm_cnt_q  <= farm_cnt_d;
            c_q         <= c_d;
            q_sat_q     <= q_sat_d;
        end
    end

    assign c         = c_q;
    assign car_count = car_count_q;
    assign q_sat     = q_sat_q;

endmodule

// File: tb/tb_farm_sensor_conditioner.sv
module tb_farm_sensor_conditioner;

    localparam logic [2:0] RED = 3'b100, YEL = 3'b010, GRN = 3'b001;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       sensor_raw = 1'b0;
    logic [2:0] light_farm = RED;
    logic [2:0] light_highway = RED;
    logic       c;
    logic [3:0] car_count;
    logic       q_sat;

    int n_total = 0;
    int n_pass  = 0;

    farm_sensor_conditioner dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sensor_raw    (sensor_raw),
        .light_farm    (light_farm),
        .light_highway (light_highway),
        .c             (c),
        .car_count     (car_count),
        .q_sat         (q_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst;
        logic       sens;
        logic [2:0] lf;
        logic [2:0] lh;
        int         n;
        int         exp_cnt;
        int         exp_c;
        int         exp_q;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input string nm, input logic r, input logic s,
                                input logic [2:0] lf, input logic [2:0] lh,
                                input int n, input int ec, input int ecc, input int eq);
        vec_t v;
        v.name = nm; v.rst = r; v.sens = s; v.lf = lf; v.lh = lh; v.n = n;
        v.exp_cnt = ec; v.exp_c = ecc; v.exp_q = eq;
        return v;
    endfunction

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic chk_all(input string nm, input int ec, input int ecc, input int eq);
        chk({nm, ".car_count"}, int'(car_count), ec);
        chk({nm, ".c"}, int'(c), ecc);
        chk({nm, ".q_sat"}, int'(q_sat), eq);
    endtask

    task automatic run_vec(input vec_t v);
        rst_n = v.rst; sensor_raw = v.sens; light_farm = v.lf; light_highway = v.lh;
        step(v.n);
        rst_n = 1'b0;
        chk_all(v.name, v.exp_cnt, v.exp_c, v.exp_q);
    endtask

    // One debounced arrival: count updates on the 7th edge of the high phase,
    // the low phase lets the debounced level fall again.
    task automatic add_car();
        sensor_raw = 1'b1; step(8);
        sensor_raw = 1'b0; step(8);
    endtask

    task automatic do_reset();
        rst_n = 1'b1; step(1); rst_n = 1'b0;
    endtask

    initial begin
        // Reset, latency and MIN_HW gating
        tbl.push_back(mk("t1_reset",   1, 0, RED, RED, 1, 0, 0, 0));
        tbl.push_back(mk("t1_e6",      0, 1, RED, GRN, 6, 0, 0, 0));
        tbl.push_back(mk("t1_e7",      0, 1, RED, GRN, 1, 1, 0, 0));
        tbl.push_back(mk("t1_e16",     0, 1, RED, GRN, 9, 1, 0, 0));
        tbl.push_back(mk("t1_e17",     0, 1, RED, GRN, 1, 1, 1, 0));
        // Glitch of 3 cycles is rejected
        tbl.push_back(mk("t2_reset",   1, 0, RED, GRN, 1, 0, 0, 0));
        tbl.push_back(mk("t2_glitch",  0, 1, RED, GRN, 3, 0, 0, 0));
        tbl.push_back(mk("t2_settle",  0, 0, RED, GRN, 10, 0, 0, 0));
        // Build a queue of 3 then drain on farm green
        tbl.push_back(mk("t3_arr1h",   0, 1, RED, GRN, 8, 1, 1, 0));
        tbl.push_back(mk("t3_arr1l",   0, 0, RED, GRN, 8, 1, 1, 0));
        tbl.push_back(mk("t3_arr2h",   0, 1, RED, GRN, 8, 2, 1, 0));
        tbl.push_back(mk("t3_arr2l",   0, 0, RED, GRN, 8, 2, 1, 0));
        tbl.push_back(mk("t3_arr3h",   0, 1, RED, GRN, 8, 3, 1, 0));
        tbl.push_back(mk("t3_arr3l",   0, 0, RED, GRN, 8, 3, 1, 0));
        tbl.push_back(mk("t3_fg7",     0, 0, GRN, RED, 7, 3, 1, 0));
        tbl.push_back(mk("t3_fg8",     0, 0, GRN, RED, 1, 2, 1, 0));
        tbl.push_back(mk("t3_fg15",    0, 0, GRN, RED, 7, 2, 1, 0));
        tbl.push_back(mk("t3_fg16",    0, 0, GRN, RED, 1, 1, 1, 0));
        tbl.push_back(mk("t3_fg23",    0, 0, GRN, RED, 7, 1, 1, 0));
        tbl.push_back(mk("t3_fg24",    0, 0, GRN, RED, 1, 0, 0, 0));
        foreach (tbl[i]) run_vec(tbl[i]);

        // Saturation at 15 with sticky q_sat
        do_reset();
        light_farm = RED; light_highway = GRN; sensor_raw = 1'b0;
        for (int i = 0; i < 15; i++) add_car();
        chk_all("t4_full", 15, 1, 0);
        add_car();
        chk_all("t4_drop", 15, 1, 1);
        step(20);
        chk("t4_sticky.q_sat", int'(q_sat), 1);
        do_reset();
        chk_all("t4_reset", 0, 0, 0);

        // MAX_FARM cut-off, yellow gate, invalid lights, re-request, then
        // coincident arrival/departure and mid-queue reset
        light_farm = RED; light_highway = GRN;
        for (int i = 0; i < 10; i++) add_car();
        chk_all("t5_queue", 10, 1, 0);
        tbl.delete();
        tbl.push_back(mk("t5_fg64",    0, 0, GRN, RED, 64, 2, 1, 0));
        tbl.push_back(mk("t5_fg65",    0, 0, GRN, RED, 1, 2, 0, 0));
        tbl.push_back(mk("t5_yellow",  0, 0, YEL, RED, 1, 2, 1, 0));
        tbl.push_back(mk("t5_bothgrn", 0, 0, GRN, GRN, 20, 2, 1, 0));
        tbl.push_back(mk("t5_hw1",     0, 0, RED, GRN, 1, 2, 0, 0));
        tbl.push_back(mk("t5_hw16",    0, 0, RED, GRN, 15, 2, 0, 0));
        tbl.push_back(mk("t5_hw17",    0, 0, RED, GRN, 1, 2, 1, 0));
        tbl.push_back(mk("t6_fg1",     0, 0, GRN, RED, 1, 2, 1, 0));
        tbl.push_back(mk("t6_pre",     0, 1, GRN, RED, 6, 2, 1, 0));
        tbl.push_back(mk("t6_coinc",   0, 1, GRN, RED, 1, 2, 1, 0));
        tbl.push_back(mk("t6_dep",     0, 1, GRN, RED, 8, 1, 1, 0));
        tbl.push_back(mk("t6_reset",   1, 1, GRN, RED, 1, 0, 0, 0));
        foreach (tbl[i]) run_vec(tbl[i]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
